eeprom_word_assembler: RTL and testbench
========================================

EEPROM_WORD_ASSEMBLER -- requirements
Module: eeprom_word_assembler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, width of accepted-word counter.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port IN_data  input  1  serial bit from EEPROM SPI controller.
REQ-006 SHALL have port IN_dataValid  input  1  IN_data/flags valid this cycle (one beat).
REQ-007 SHALL have port IN_dataByte  input  1  beat carries last bit of a byte.
REQ-008 SHALL have port IN_dataWord  input  1  beat carries last bit of a 32-bit word.
REQ-009 SHALL have port IN_flush  input  1  clear FIFO, bit counter, checksum.
REQ-010 SHALL have port OUT_word  output  32  head-of-FIFO word.
REQ-011 SHALL have port OUT_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port IN_ready  input  1  consumer accepts OUT_word when OUT_valid.
REQ-013 SHALL have port OUT_wordCnt  output  CNT_W  words pushed into FIFO, wraps.
REQ-014 SHALL have port OUT_overflow  output  1  sticky: completed word dropped, FIFO full.
REQ-015 SHALL have port OUT_alignErr  output  1  sticky: flag/bit-count mismatch.
REQ-016 SHALL have port OUT_cksum  output  32  running checksum (see Configuration).

Function
REQ-017 SHALL shift IN_data into 32-bit shift register MSB-first (new bit enters bit 0, shift left) on each IN_dataValid beat.
REQ-018 SHALL keep 5-bit bit counter: +1 per valid beat, 0 after word completes or on error.
REQ-019 SHALL complete a word on a valid beat with IN_dataWord=1 and bit counter=31; word = shifted value including that beat.
REQ-020 SHALL set OUT_alignErr and drop the partial word (counter to 0) if: IN_dataWord=1 with counter!=31; counter=31 beat without IN_dataWord; IN_dataByte value != (counter[2:0]==7).
REQ-021 SHALL push a completed word into the FIFO the same edge; OUT_valid high next cycle (1-cycle latency from flag beat).
REQ-022 SHALL pop on OUT_valid & IN_ready; OUT_word changes only after pop or when empty FIFO receives a push.
REQ-023 SHALL, when FIFO full with no pop that cycle, drop the completed word, set OUT_overflow, not increment OUT_wordCnt.
REQ-024 SHALL, when full with simultaneous pop and push, accept both; occupancy unchanged, no overflow.
REQ-025 SHALL, when empty, ignore IN_ready; simultaneous push into empty FIFO leaves it with 1 entry.
REQ-026 SHALL increment OUT_wordCnt per accepted push, wrapping 2^CNT_W-1 -> 0.
REQ-027 SHALL on IN_flush: empty FIFO, zero bit counter and shift register, zero checksum; beat and pop in same cycle ignored; sticky flags and OUT_wordCnt kept.
REQ-028 SHALL use pointer-based FIFO with DEPTH+1-state occupancy; full = DEPTH entries.

Reset
REQ-029 SHALL on rst=0 at clk edge: FIFO empty, OUT_valid=0, OUT_word=0, bit counter/shift register=0, OUT_wordCnt=0, OUT_overflow=0, OUT_alignErr=0, OUT_cksum=0.
REQ-030 SHALL discard any partial word or in-flight push on reset mid-operation; reset takes priority over flush and all inputs.

Configuration
REQ-031 SHALL, with macro EEPROM_ASSEMBLER_CKSUM_EN defined, update OUT_cksum = OUT_cksum + word (mod 2^32) for each accepted push, visible next cycle.
REQ-032 SHALL, without EEPROM_ASSEMBLER_CKSUM_EN, drive OUT_cksum constant 0 with no adder logic; port still present.

Verification
REQ-033 SHALL cover: 32 beats of 0xDEADBEEF MSB-first, byte flags on bits 7/15/23/31, word flag on bit 31 -> OUT_valid next cycle, OUT_word=0xDEADBEEF, OUT_wordCnt=1.
REQ-034 SHALL cover: IN_ready=0, push 5 words (DEPTH=4) -> first 4 retained in order, OUT_overflow=1, OUT_wordCnt=4; then push with IN_ready=1 while full -> accepted, no further change to overflow.
REQ-035 SHALL cover: word flag on 20th bit -> OUT_alignErr=1, no push; next 32-bit word 0x12345678 assembles correctly.
REQ-036 SHALL cover: rst=0 after 10 bits, then full word 0xA5A5A5A5 -> only 0xA5A5A5A5 delivered, all flags 0.
REQ-037 SHALL cover: with EEPROM_ASSEMBLER_CKSUM_EN, words 0xFFFFFFFF and 0x00000002 -> OUT_cksum=0x00000001; IN_flush -> 0; without macro OUT_cksum stays 0.

Source files
------------

// File: rtl/eeprom_word_assembler.sv
// Assembles serial EEPROM bits into 32-bit words and queues them in a small output FIFO.
// Define EEPROM_ASSEMBLER_CKSUM_EN to enable the running 32-bit additive checksum on OUT_cksum.
module eeprom_word_assembler #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IN_data,
    input  logic             IN_dataValid,
    input  logic             IN_dataByte,
    input  logic             IN_dataWord,
    input  logic             IN_flush,
    output logic [31:0]      OUT_word,
    output logic             OUT_valid,
    input  logic             IN_ready,
    output logic [CNT_W-1:0] OUT_wordCnt,
    output logic             OUT_overflow,
    output logic             OUT_alignErr,
    output logic [31:0]      OUT_cksum
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = AW + 1;

    // Bit 31 of the shift register is always shifted out when a word completes, so only 31 bits are held.
    logic [30:0]      sr_q, sr_d;
    logic [4:0]       bcnt_q, bcnt_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [31:0]      head_q, head_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             ovf_q, ovf_d;
    logic             align_q, align_d;
    logic [31:0]      mem [DEPTH];

    logic [31:0]      word_c;
    logic             beat_c, err_c, done_c, full_c, pop_c, push_c;

    // Beat decode, alignment checking and FIFO bookkeeping.
    always_comb begin
        word_c   = {sr_q, IN_data};
        beat_c   = IN_dataValid && !IN_flush;
        err_c    = 1'b0;
        done_c   = 1'b0;
        full_c   = (occ_q == OW'(DEPTH));
        pop_c    = valid_q && IN_ready && !IN_flush;
        push_c   = 1'b0;
        sr_d     = sr_q;
        bcnt_d   = bcnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        head_d   = head_q;
        valid_d  = valid_q;
        wcnt_d   = wcnt_q;
        ovf_d    = ovf_q;
        align_d  = align_q;

        if (beat_c) begin
            err_c  = (IN_dataWord && (bcnt_q != 5'd31))
                  || (!IN_dataWord && (bcnt_q == 5'd31))
                  || (IN_dataByte != (bcnt_q[2:0] == 3'd7));
            done_c = IN_dataWord && !err_c;
        end
        push_c = done_c && (!full_c || pop_c);

        if (IN_flush) begin
            sr_d     = '0;
            bcnt_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            valid_d  = 1'b0;
        end else begin
            if (beat_c) begin
                sr_d   = word_c[30:0];
                bcnt_d = (err_c || done_c) ? 5'd0 : bcnt_q + 5'd1;
            end
            if (err_c) begin
                align_d = 1'b1;
            end
            if (done_c && !push_c) begin
                ovf_d = 1'b1;
            end
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                wcnt_d   = wcnt_q + CNT_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            occ_d = occ_q + OW'(push_c) - OW'(pop_c);
            // Head register tracks the entry at rd_ptr; a push into an (about to be) empty FIFO bypasses memory.
            if (push_c && ((occ_q == '0) || (pop_c && (occ_q == OW'(1))))) begin
                head_d = word_c;
            end else if (pop_c && (occ_q > OW'(1))) begin
                head_d = mem[rd_ptr_q + AW'(1)];
            end
            valid_d = (occ_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_q     <= '0;
            bcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            wcnt_q   <= '0;
            ovf_q    <= 1'b0;
            align_q  <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            bcnt_q   <= bcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            wcnt_q   <= wcnt_d;
            ovf_q    <= ovf_d;
            align_q  <= align_d;
        end
    end

    // FIFO storage needs no reset; occupancy and the head register define what is visible.
    always_ff @(posedge clk) begin
        if (rst && push_c && !IN_flush) begin
            mem[wr_ptr_q] <= word_c;
        end
    end

`ifdef EEPROM_ASSEMBLER_CKSUM_EN
    logic [31:0] cksum_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cksum_q <= '0;
        end else if (IN_flush) begin
            cksum_q <= '0;
        end else if (push_c) begin
            cksum_q <= cksum_q + word_c;
        end
    end

    assign OUT_cksum = cksum_q;
`else
    assign OUT_cksum = '0;
`endif

    assign OUT_word     = head_q;
    assign OUT_valid    = valid_q;
    assign OUT_wordCnt  = wcnt_q;
    assign OUT_overflow = ovf_q;
    assign OUT_alignErr = align_q;

endmodule

// File: tb/tb_eeprom_word_assembler.sv
// Directed self-checking bench for eeprom_word_assembler (DEPTH=4, CNT_W=16).
module tb_eeprom_word_assembler;

    logic        clk;
    logic        rst;
    logic        IN_data;
    logic        IN_dataValid;
    logic        IN_dataByte;
    logic        IN_dataWord;
    logic        IN_flush;
    logic [31:0] OUT_word;
    logic        OUT_valid;
    logic        IN_ready;
    logic [15:0] OUT_wordCnt;
    logic        OUT_overflow;
    logic        OUT_alignErr;
    logic [31:0] OUT_cksum;

    int errors;
    int checks;

    eeprom_word_assembler #(.DEPTH(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .IN_data      (IN_data),
        .IN_dataValid (IN_dataValid),
        .IN_dataByte  (IN_dataByte),
        .IN_dataWord  (IN_dataWord),
        .IN_flush     (IN_flush),
        .OUT_word     (OUT_word),
        .OUT_valid    (OUT_valid),
        .IN_ready     (IN_ready),
        .OUT_wordCnt  (OUT_wordCnt),
        .OUT_overflow (OUT_overflow),
        .OUT_alignErr (OUT_alignErr),
        .OUT_cksum    (OUT_cksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sends the top n bits of w MSB-first; byte flags on every 8th bit, optional word flag on the last beat.
    task automatic drive_bits(input logic [31:0] w, input int n, input bit wlast, input bit rlast);
        for (int i = 31; i >= 32 - n; i--) begin
            @(negedge clk);
            IN_dataValid = 1'b1;
            IN_data      = w[i];
            IN_dataByte  = ((i % 8) == 0);
            IN_dataWord  = wlast && (i == 32 - n);
            IN_ready     = rlast && (i == 32 - n);
        end
        @(negedge clk);
        IN_dataValid = 1'b0;
        IN_data      = 1'b0;
        IN_dataByte  = 1'b0;
        IN_dataWord  = 1'b0;
        IN_ready     = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst          = 1'b0;
        IN_data      = 1'b0;
        IN_dataValid = 1'b0;
        IN_dataByte  = 1'b0;
        IN_dataWord  = 1'b0;
        IN_flush     = 1'b0;
        IN_ready     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", OUT_valid); end
        checks++; if (OUT_word !== 32'h0) begin errors++; $display("FAIL reset_word got=%h exp=0", OUT_word); end
        checks++; if (OUT_wordCnt !== 16'h0) begin errors++; $display("FAIL reset_wcnt got=%0d exp=0", OUT_wordCnt); end
        checks++; if (OUT_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", OUT_overflow); end
        checks++; if (OUT_alignErr !== 1'b0) begin errors++; $display("FAIL reset_align got=%b exp=0", OUT_alignErr); end
        checks++; if (OUT_cksum !== 32'h0) begin errors++; $display("FAIL reset_cksum got=%h exp=0", OUT_cksum); end
    endtask

    task automatic test_basic_word();
        apply_reset();
        drive_bits(32'hDEADBEEF, 32, 1'b1, 1'b0);
        checks++; if (OUT_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", OUT_valid); end
        checks++; if (OUT_word !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_word got=%h exp=deadbeef", OUT_word); end
        checks++; if (OUT_wordCnt !== 16'd1) begin errors++; $display("FAIL basic_wcnt got=%0d exp=1", OUT_wordCnt); end
        checks++; if (OUT_alignErr !== 1'b0) begin errors++; $display("FAIL basic_align got=%b exp=0", OUT_alignErr); end
        IN_ready = 1'b1;
        @(negedge clk);
        IN_ready = 1'b0;
        checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_valid got=%b exp=0", OUT_valid); end
        checks++; if (OUT_wordCnt !== 16'd1) begin errors++; $display("FAIL basic_pop_wcnt got=%0d exp=1", OUT_wordCnt); end
    endtask

    task automatic test_overflow();
        logic [31:0] words [6];
        logic [31:0] drain [4];
        words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
        words[3] = 32'h44444444; words[4] = 32'h55555555; words[5] = 32'h66666666;
        drain[0] = 32'h22222222; drain[1] = 32'h33333333; drain[2] = 32'h44444444; drain[3] = 32'h66666666;
        apply_reset();
        for (int k = 0; k < 5; k++) drive_bits(words[k], 32, 1'b1, 1'b0);
        checks++; if (OUT_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", OUT_overflow); end
        checks++; if (OUT_wordCnt !== 16'd4) begin errors++; $display("FAIL ovf_wcnt got=%0d exp=4", OUT_wordCnt); end
        checks++; if (OUT_word !== 32'h11111111) begin errors++; $display("FAIL ovf_head got=%h exp=11111111", OUT_word); end
        // Sixth word completes on the same edge the head is popped: both are accepted.
        drive_bits(words[5], 32, 1'b1, 1'b1);
        checks++; if (OUT_wordCnt !== 16'd5) begin errors++; $display("FAIL fullpush_wcnt got=%0d exp=5", OUT_wordCnt); end
        checks++; if (OUT_overflow !== 1'b1) begin errors++; $display("FAIL fullpush_ovf got=%b exp=1", OUT_overflow); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (OUT_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got=%b exp=1", k, OUT_valid); end
            checks++; if (OUT_word !== drain[k]) begin errors++; $display("FAIL drain_word[%0d] got=%h exp=%h", k, OUT_word, drain[k]); end
            IN_ready = 1'b1;
            @(negedge clk);
        end
        IN_ready = 1'b0;
        checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", OUT_valid); end
    endtask

    task automatic test_align();
        apply_reset();
        drive_bits(32'hFFFFF000, 20, 1'b1, 1'b0);
        checks++; if (OUT_alignErr !== 1'b1) begin errors++; $display("FAIL align_flag got=%b exp=1", OUT_alignErr); end
        checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL align_nopush got=%b exp=0", OUT_valid); end
        checks++; if (OUT_wordCnt !== 16'd0) begin errors++; $display("FAIL align_wcnt got=%0d exp=0", OUT_wordCnt); end
        drive_bits(32'h12345678, 32, 1'b1, 1'b0);
        checks++; if (OUT_word !== 32'h12345678) begin errors++; $display("FAIL align_next_word got=%h exp=12345678", OUT_word); end
        checks++; if (OUT_valid !== 1'b1) begin errors++; $display("FAIL align_next_valid got=%b exp=1", OUT_valid); end
        checks++; if (OUT_wordCnt !== 16'd1) begin errors++; $display("FAIL align_next_wcnt got=%0d exp=1", OUT_wordCnt); end
    endtask

    task automatic test_reset_mid();
        drive_bits(32'hFFC00000, 10, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drive_bits(32'hA5A5A5A5, 32, 1'b1, 1'b0);
        checks++; if (OUT_word !== 32'hA5A5A5A5) begin errors++; $display("FAIL rstmid_word got=%h exp=a5a5a5a5", OUT_word); end
        checks++; if (OUT_wordCnt !== 16'd1) begin errors++; $display("FAIL rstmid_wcnt got=%0d exp=1", OUT_wordCnt); end
        checks++; if (OUT_alignErr !== 1'b0) begin errors++; $display("FAIL rstmid_align got=%b exp=0", OUT_alignErr); end
        checks++; if (OUT_overflow !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got=%b exp=0", OUT_overflow); end
        IN_ready = 1'b1;
        @(negedge clk);
        IN_ready = 1'b0;
        checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL rstmid_single got=%b exp=0", OUT_valid); end
    endtask

    task automatic test_cksum_flush();
        logic [31:0] exp_ck;
`ifdef EEPROM_ASSEMBLER_CKSUM_EN
        exp_ck = 32'h00000001;
`else
        exp_ck = 32'h00000000;
`endif
        apply_reset();
        drive_bits(32'hFFFFFFFF, 32, 1'b1, 1'b0);
        drive_bits(32'h00000002, 32, 1'b1, 1'b0);
        checks++; if (OUT_cksum !== exp_ck) begin errors++; $display("FAIL cksum_sum got=%h exp=%h", OUT_cksum, exp_ck); end
        drive_bits(32'hF8000000, 5, 1'b0, 1'b0);
        IN_flush = 1'b1;
        @(negedge clk);
        IN_flush = 1'b0;
        checks++; if (OUT_cksum !== 32'h0) begin errors++; $display("FAIL flush_cksum got=%h exp=0", OUT_cksum); end
        checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", OUT_valid); end
        checks++; if (OUT_wordCnt !== 16'd2) begin errors++; $display("FAIL flush_wcnt got=%0d exp=2", OUT_wordCnt); end
        drive_bits(32'h0F0F0F0F, 32, 1'b1, 1'b0);
        checks++; if (OUT_word !== 32'h0F0F0F0F) begin errors++; $display("FAIL flush_next_word got=%h exp=0f0f0f0f", OUT_word); end
        checks++; if (OUT_alignErr !== 1'b0) begin errors++; $display("FAIL flush_next_align got=%b exp=0", OUT_alignErr); end
        checks++; if (OUT_wordCnt !== 16'd3) begin errors++; $display("FAIL flush_next_wcnt got=%0d exp=3", OUT_wordCnt); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst          = 1'b0;
        IN_data      = 1'b0;
        IN_dataValid = 1'b0;
        IN_dataByte  = 1'b0;
        IN_dataWord  = 1'b0;
        IN_flush     = 1'b0;
        IN_ready     = 1'b0;
        test_reset();
        test_basic_word();
        test_overflow();
        test_align();
        test_reset_mid();
        test_cksum_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
